sprite_compositor: RTL

- Parametrised, pipelined pixel compositor for the 640x480 VGA path.
- Overlays N_SPR sprite layers on a scaled background and drives 12-bit RGB.
- Sprite and background image ROMs sit outside the block: it emits ROM addresses and takes back pixel data one cycle later.
- Adds a per-frame sprite-collision detector and pipeline-aligned sync/valid outputs.

---
 rtl/vga_pkg.sv | 19 +
 rtl/sprite_window.sv | 56 +++++
 rtl/sprite_compositor.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared VGA geometry constants and small helpers for the sprite compositor.
// Imported by the compositor top and the per-layer sprite window.
package vga_pkg;

    localparam int H_ACT   = 640;
    localparam int V_ACT   = 480;
    localparam int COORD_W = 10;
    localparam int RGB_W   = 12;

    localparam logic [COORD_W-1:0] H_LAST = 10'd639;
    localparam logic [COORD_W-1:0] V_LAST = 10'd479;

    typedef logic [RGB_W-1:0] rgb_t;

    function automatic logic is_frame_end(input logic [COORD_W-1:0] h, input logic [COORD_W-1:0] v);
        return (h == H_LAST) && (v == V_LAST);
    endfunction

endpackage

// File: rtl/sprite_window.sv
// Stage-1 hit test and ROM address for one W x H sprite centred at (x, y).
// Signed 12-bit arithmetic so sprites clipped at the left/top edge never wrap.
module sprite_window
    import vga_pkg::*;
#(
    parameter int W      = 15,
    parameter int H      = 15,
    parameter int ADDR_W = 17
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [COORD_W-1:0] hc,
    input  logic [COORD_W-1:0] vc,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic               en,
    output logic               hit,
    output logic [ADDR_W-1:0]  addr
);

    localparam logic signed [11:0] W_S  = 12'(W);
    localparam logic signed [11:0] H_S  = 12'(H);
    localparam logic signed [11:0] HW_S = 12'(W / 2);
    localparam logic signed [11:0] HH_S = 12'(H / 2);
    localparam logic [ADDR_W-1:0]  W_A  = ADDR_W'(W);

    logic signed [11:0] dx_s;
    logic signed [11:0] dy_s;
    logic               hit_s;
    logic [ADDR_W-1:0]  addr_s;

    // offsets from the sprite's top-left corner and the resulting hit/address
    always_comb begin
        dx_s   = $signed({2'b00, hc}) - ($signed({2'b00, x}) - HW_S);
        dy_s   = $signed({2'b00, vc}) - ($signed({2'b00, y}) - HH_S);
        hit_s  = en && (dx_s >= 12'sd0) && (dx_s < W_S) && (dy_s >= 12'sd0) && (dy_s < H_S);
        addr_s = '0;
        if (hit_s) begin
            addr_s = ADDR_W'(dx_s) + W_A * ADDR_W'(dy_s);
        end else begin
            addr_s = '0;
        end
    end

    // stage-1 register: drives the sprite ROM address directly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit  <= 1'b0;
            addr <= '0;
        end else begin
            hit  <= hit_s;
            addr <= addr_s;
        end
    end

endmodule

// File: rtl/sprite_compositor.sv
// Three-stage sprite-over-background compositor with per-frame collision flags.
// Stage 1 issues ROM addresses, stage 2 receives ROM data, stage 3 registers RGB.
module sprite_compositor
    import vga_pkg::*;
#(
    parameter int                 N_SPR     = 4,
    parameter logic [8*N_SPR-1:0] SPR_W     = {8'd50, 8'd30, 8'd15, 8'd15},
    parameter logic [8*N_SPR-1:0] SPR_H     = {8'd75, 8'd50, 8'd15, 8'd15},
    parameter int                 ADDR_W    = 17,
    parameter int                 BG_SHIFT  = 1,
    parameter int                 BG_W      = 320,
    parameter logic [RGB_W-1:0]   TRANS_KEY = 12'h000
) (
    input  logic                        clk_25m,
    input  logic                        rst,
    input  logic [COORD_W-1:0]          hc,
    input  logic [COORD_W-1:0]          vc,
    input  logic                        valid,
    input  logic [1:0]                  sync_in,
    input  logic [COORD_W*N_SPR-1:0]    spr_x,
    input  logic [COORD_W*N_SPR-1:0]    spr_y,
    input  logic [N_SPR-1:0]            spr_en,
    output logic [ADDR_W*N_SPR-1:0]     spr_addr,
    input  logic [RGB_W*N_SPR-1:0]      spr_data,
    output logic [ADDR_W-1:0]           bg_addr,
    input  logic [RGB_W-1:0]            bg_data,
    output logic [3:0]                  vgaRed,
    output logic [3:0]                  vgaGreen,
    output logic [3:0]                  vgaBlue,
    output logic [1:0]                  sync_out,
    output logic [N_SPR-1:0]            collide,
    output logic                        collide_stb
);

    logic               rst_meta_r;
    logic               rst_n_r;
    logic [N_SPR-1:0]   hit_s1;
    logic [N_SPR-1:0]   hit_s2;
    logic               valid_s1, valid_s2;
    logic [1:0]         sync_s1, sync_s2;
    logic [COORD_W-1:0] hc_s1, hc_s2, vc_s1, vc_s2;
    logic [N_SPR-1:0]   opaque_s;
    logic [N_SPR-1:0]   terms_s;
    logic               frame_end_s;
    rgb_t               pix_s;
    rgb_t               rgb_r;
    logic [N_SPR-1:0]   acc_r;

    // reset asserts asynchronously, releases two clocks later
    always_ff @(posedge clk_25m or negedge rst) begin
        if (!rst) begin
            rst_meta_r <= 1'b0;
            rst_n_r    <= 1'b0;
        end else begin
            rst_meta_r <= 1'b1;
            rst_n_r    <= rst_meta_r;
        end
    end

    for (genvar i = 0; i < N_SPR; i++) begin : g_spr
        sprite_window #(
            .W      (int'(SPR_W[8*i +: 8])),
            .H      (int'(SPR_H[8*i +: 8])),
            .ADDR_W (ADDR_W)
        ) u_win (
            .clk   (clk_25m),
            .rst_n (rst_n_r),
            .hc    (hc),
            .vc    (vc),
            .x     (spr_x[COORD_W*i +: COORD_W]),
            .y     (spr_y[COORD_W*i +: COORD_W]),
            .en    (spr_en[i]),
            .hit   (hit_s1[i]),
            .addr  (spr_addr[ADDR_W*i +: ADDR_W])
        );
    end

    // background address plus the delay line that tracks each pixel to stage 3
    always_ff @(posedge clk_25m or negedge rst_n_r) begin
        if (!rst_n_r) begin
            bg_addr  <= '0;
            hit_s2   <= '0;
            valid_s1 <= 1'b0;
            valid_s2 <= 1'b0;
            sync_s1  <= 2'b00;
            sync_s2  <= 2'b00;
            hc_s1    <= '0;
            hc_s2    <= '0;
            vc_s1    <= '0;
            vc_s2    <= '0;
        end else begin
            bg_addr  <= ADDR_W'(hc >> BG_SHIFT) + ADDR_W'(BG_W) * ADDR_W'(vc >> BG_SHIFT);
            hit_s2   <= hit_s1;
            valid_s1 <= valid;
            valid_s2 <= valid_s1;
            sync_s1  <= sync_in;
            sync_s2  <= sync_s1;
            hc_s1    <= hc;
            hc_s2    <= hc_s1;
            vc_s1    <= vc;
            vc_s2    <= vc_s1;
        end
    end

    // lowest-index opaque layer wins; collision terms are layer 0 against each other layer
    always_comb begin
        opaque_s = '0;
        terms_s  = '0;
        pix_s    = bg_data;
        for (int i = N_SPR - 1; i >= 0; i--) begin
            opaque_s[i] = hit_s2[i] && (spr_data[RGB_W*i +: RGB_W] != TRANS_KEY);
            pix_s       = opaque_s[i] ? spr_data[RGB_W*i +: RGB_W] : pix_s;
        end
        for (int i = 1; i < N_SPR; i++) begin
            terms_s[i] = opaque_s[0] && opaque_s[i] && valid_s2;
        end
        frame_end_s = is_frame_end(hc_s2, vc_s2);
    end

    // stage 3: pixel colour, aligned sync and the frame collision accumulator
    always_ff @(posedge clk_25m or negedge rst_n_r) begin
        if (!rst_n_r) begin
            rgb_r       <= '0;
            sync_out    <= 2'b00;
            collide     <= '0;
            collide_stb <= 1'b0;
            acc_r       <= '0;
        end else begin
            rgb_r    <= valid_s2 ? pix_s : 12'h000;
            sync_out <= sync_s2;
            if (frame_end_s) begin
                collide     <= acc_r | terms_s;
                acc_r       <= '0;
                collide_stb <= 1'b1;
            end else begin
                acc_r       <= acc_r | terms_s;
                collide_stb <= 1'b0;
            end
        end
    end

    assign {vgaRed, vgaGreen, vgaBlue} = rgb_r;

endmodule
